ball_draw_pipeline: RTL and testbench

// - Multi-ball, pipelined successor of the single-ball draw check in the pong video path.
// - Per pixel: reports whether any enabled ball covers (drawX, drawY), which ball, and ball-ball overlap.
// - Sits between the VGA timing counters and the pixel colour mux; output latency is fixed and matches the colour pipeline.
// - Ball positions are frame-latched (no tearing); the Y test is evaluated once per line.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/ball_span_check.sv | 19 +
 rtl/ball_draw_pipeline.sv | 111 +++++++++++
 tb/tb_ball_draw_pipeline.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong video-path constants, the ball record type and the hit-vector
// helpers used by the multi-ball draw pipeline.
package pong_pkg;
  localparam int H_CNT_WID_DFLT    = 10;
  localparam int V_CNT_WID_DFLT    = 10;
  localparam int BALL_PIXSIZE_DFLT = 8;
  localparam int MAX_BALLS         = 8;
  localparam int MAX_ID_WID        = 3;

  typedef struct packed {
    logic [H_CNT_WID_DFLT-1:0] x;
    logic [V_CNT_WID_DFLT-1:0] y;
    logic                      en;
  } ball_pos_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [MAX_ID_WID-1:0] lowestHit(input logic [MAX_BALLS-1:0] hits);
    logic [MAX_ID_WID-1:0] idx;
    idx = '0;
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      if (hits[i]) idx = MAX_ID_WID'(i);
    end
    return idx;
  endfunction

  function automatic logic multiHit(input logic [MAX_BALLS-1:0] hits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      cnt += int'(hits[i]);
    end
    return cnt >= 2;
  endfunction
endpackage

// File: rtl/ball_span_check.sv
// Combinational test of pos against the half-open span [lo, lo+SIZE). The end
// of the span is formed one bit wider so a ball near the top edge never wraps.
module ball_span_check
  import pong_pkg::*;
#(
  parameter int WID  = H_CNT_WID_DFLT,
  parameter int SIZE = BALL_PIXSIZE_DFLT
) (
  input  logic [WID-1:0] lo,
  input  logic [WID-1:0] pos,
  output logic           inSpan
);
  localparam logic [WID:0] SIZE_EXT = (WID + 1)'(SIZE);

  logic [WID:0] hiExcl;

  assign hiExcl = {1'b0, lo} + SIZE_EXT;
  assign inSpan = (pos >= lo) && ({1'b0, pos} < hiExcl);
endmodule

// File: rtl/ball_draw_pipeline.sv
// Multi-ball draw check: frame-latched ball positions, per-line Y test, per-pixel
// X test, then a pixel_en-qualified delay line that matches the colour pipeline.
module ball_draw_pipeline
  import pong_pkg::*;
#(
  parameter int PIPELINE_STAGES = 2,
  parameter int H_CNT_WID       = H_CNT_WID_DFLT,
  parameter int V_CNT_WID       = V_CNT_WID_DFLT,
  parameter int NUM_BALLS       = 2,
  parameter int BALL_PIXSIZE    = BALL_PIXSIZE_DFLT,
  parameter int ID_WID          = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pixel_en,
  input  logic                           frameStart,
  input  logic                           lineStart,
  input  logic [H_CNT_WID-1:0]           drawX,
  input  logic [V_CNT_WID-1:0]           drawY,
  input  logic [NUM_BALLS*H_CNT_WID-1:0] ballX,
  input  logic [NUM_BALLS*V_CNT_WID-1:0] ballY,
  input  logic [NUM_BALLS-1:0]           ballEn,
  output logic                           isBallPos,
  output logic [ID_WID-1:0]              ballId,
  output logic                           overlap,
  output logic                           collided
);
  logic [NUM_BALLS*H_CNT_WID-1:0] sX;
  logic [NUM_BALLS*V_CNT_WID-1:0] sY;
  logic [NUM_BALLS*V_CNT_WID-1:0] yLo;
  logic [NUM_BALLS-1:0]           sEn, yEn, yValid, xHit, yHit, hit;
  logic [MAX_BALLS-1:0]           hitPad;

  logic              stAny [PIPELINE_STAGES];
  logic [ID_WID-1:0] stId  [PIPELINE_STAGES];
  logic              stOvl [PIPELINE_STAGES];

  // A line test issued on the frameStart edge must see the incoming positions.
  assign yLo = frameStart ? ballY : sY;
  assign yEn = frameStart ? ballEn : sEn;

  for (genvar i = 0; i < NUM_BALLS; i++) begin : gBall
    ball_span_check #(.WID(H_CNT_WID), .SIZE(BALL_PIXSIZE)) uX (
      .lo     (sX[i*H_CNT_WID +: H_CNT_WID]),
      .pos    (drawX),
      .inSpan (xHit[i])
    );
    ball_span_check #(.WID(V_CNT_WID), .SIZE(BALL_PIXSIZE)) uY (
      .lo     (yLo[i*V_CNT_WID +: V_CNT_WID]),
      .pos    (drawY),
      .inSpan (yHit[i])
    );
  end

  assign hit    = xHit & yValid;
  assign hitPad = MAX_BALLS'(hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sX  <= '0;
      sY  <= '0;
      sEn <= '0;
    end else if (frameStart) begin
      sX  <= ballX;
      sY  <= ballY;
      sEn <= ballEn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yValid <= '0;
    end else if (lineStart) begin
      yValid <= yEn & yHit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < PIPELINE_STAGES; s++) begin
        stAny[s] <= 1'b0;
        stId[s]  <= '0;
        stOvl[s] <= 1'b0;
      end
    end else if (pixel_en) begin
      stAny[0] <= |hit;
      stId[0]  <= ID_WID'(lowestHit(hitPad));
      stOvl[0] <= multiHit(hitPad);
      for (int s = 1; s < PIPELINE_STAGES; s++) begin
        stAny[s] <= stAny[s-1];
        stId[s]  <= stId[s-1];
        stOvl[s] <= stOvl[s-1];
      end
    end
  end

  assign isBallPos = stAny[PIPELINE_STAGES-1];
  assign ballId    = stId[PIPELINE_STAGES-1];
  assign overlap   = stOvl[PIPELINE_STAGES-1];

  // Sticky collision flag; frameStart clear takes priority over a same-cycle overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collided <= 1'b0;
    end else if (frameStart) begin
      collided <= 1'b0;
    end else begin
      collided <= collided | overlap;
    end
  end
endmodule

// File: tb/tb_ball_draw_pipeline.sv
// Scoreboard bench for ball_draw_pipeline: stimulus pushes expected pixel results
// from an arithmetic reference model, a monitor pops them at output time.
module tb_ball_draw_pipeline;
  import pong_pkg::*;

  localparam int PIPE = 2;
  localparam int HW   = 10;
  localparam int VW   = 10;
  localparam int NB   = 2;
  localparam int SZ   = 8;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst, pixelEn, frameStart, lineStart;
  logic [HW-1:0]    drawX;
  logic [VW-1:0]    drawY;
  logic [NB*HW-1:0] ballX;
  logic [NB*VW-1:0] ballY;
  logic [NB-1:0]    ballEn;
  logic             isBallPos, overlap, collided;
  logic [IDW-1:0]   ballId;

  ball_draw_pipeline #(
    .PIPELINE_STAGES (PIPE),
    .H_CNT_WID       (HW),
    .V_CNT_WID       (VW),
    .NUM_BALLS       (NB),
    .BALL_PIXSIZE    (SZ),
    .ID_WID          (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_en   (pixelEn),
    .frameStart (frameStart),
    .lineStart  (lineStart),
    .drawX      (drawX),
    .drawY      (drawY),
    .ballX      (ballX),
    .ballY      (ballY),
    .ballEn     (ballEn),
    .isBallPos  (isBallPos),
    .ballId     (ballId),
    .overlap    (overlap),
    .collided   (collided)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit any;
    int id;
    bit ovl;
  } exp_t;

  exp_t sb[$];
  int   nCmp = 0;
  int   nBad = 0;

  // Reference model state: frame shadow and per-line coverage.
  int mX [NB];
  int mY [NB];
  bit mEn[NB];
  bit mYv[NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit covers(input int lo, input int pos);
    return (pos >= lo) && (pos < lo + SZ);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NB; i++) begin
      mX[i] = 0; mY[i] = 0; mEn[i] = 0; mYv[i] = 0;
    end
  endfunction

  task automatic setBall(input int i, input int x, input int y, input bit en);
    ballX[i*HW +: HW] = HW'(x);
    ballY[i*VW +: VW] = VW'(y);
    ballEn[i]         = en;
  endtask

  // One clock of stimulus; the expected pixel result uses state from before this edge.
  task automatic cyc(input bit pe, input bit fs, input bit ls, input int x, input int y);
    exp_t e;
    int   n;
    @(negedge clk);
    pixelEn = pe; frameStart = fs; lineStart = ls;
    drawX = HW'(x); drawY = VW'(y);
    if (pe) begin
      e = '{any: 1'b0, id: 0, ovl: 1'b0};
      n = 0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (mYv[i] && covers(mX[i], x)) begin
          n++; e.any = 1'b1; e.id = i;
        end
      end
      e.ovl = (n >= 2);
      sb.push_back(e);
    end
    if (fs) begin
      for (int i = 0; i < NB; i++) begin
        mX[i]  = int'(ballX[i*HW +: HW]);
        mY[i]  = int'(ballY[i*VW +: VW]);
        mEn[i] = ballEn[i];
      end
    end
    if (ls) begin
      for (int i = 0; i < NB; i++) mYv[i] = mEn[i] && covers(mY[i], y);
    end
  endtask

  task automatic newFrame();
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic newLine(input int y);
    cyc(0, 0, 1, 0, y);
  endtask

  task automatic scan(input int x0, input int x1);
    for (int x = x0; x <= x1; x++) cyc(1, 0, 0, x, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: tracks which expected result sits at the output stage and checks every cycle.
  initial begin : monitor
    exp_t inflight[$];
    exp_t cur;
    exp_t zero;
    bit   col, pe, fs, r;
    zero = '{any: 1'b0, id: 0, ovl: 1'b0};
    cur  = zero;
    col  = 1'b0;
    forever begin
      @(posedge clk);
      pe = pixelEn; fs = frameStart; r = rst;
      #1;
      if (r) begin
        inflight.delete();
        for (int k = 0; k < PIPE - 1; k++) inflight.push_back(zero);
        cur = zero;
        col = 1'b0;
      end else begin
        col = fs ? 1'b0 : (col | cur.ovl);
        if (pe) begin
          if (sb.size() == 0) begin
            nCmp++; nBad++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
          end else begin
            inflight.push_back(sb.pop_front());
          end
          if (inflight.size() >= PIPE) cur = inflight.pop_front();
        end
      end
      chk("isBallPos", 32'(isBallPos), 32'(cur.any));
      chk("ballId",    32'(ballId),    32'(cur.id));
      chk("overlap",   32'(overlap),   32'(cur.ovl));
      chk("collided",  32'(collided),  32'(col));
    end
  end

  initial begin : stimulus
    rst = 1'b1; pixelEn = 1'b0; frameStart = 1'b0; lineStart = 1'b0;
    drawX = '0; drawY = '0; ballX = '0; ballY = '0; ballEn = '0;
    modelReset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_isBallPos", 32'(isBallPos), 32'd0);
    chk("reset_collided",  32'(collided),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single ball at (100,50), line 53.
    setBall(0, 100, 50, 1'b1);
    setBall(1, 600, 600, 1'b0);
    newFrame();
    newLine(53);
    scan(95, 112);
    idle(3);

    // Two balls overlapping on columns 104..107; collided sticks until frameStart.
    setBall(1, 104, 50, 1'b1);
    newFrame();
    newLine(55);
    scan(98, 112);
    idle(5);
    newLine(57);
    scan(100, 110);
    newFrame();
    idle(3);

    // Right/bottom edge: no wrap to column 0 or row 0.
    setBall(0, 1020, 1020, 1'b1);
    setBall(1, 0, 0, 1'b0);
    newFrame();
    newLine(1021);
    scan(1016, 1023);
    scan(0, 5);
    newLine(2);
    scan(1018, 1023);
    scan(0, 3);

    // Position change without frameStart is invisible until the next frame.
    setBall(0, 200, 1020, 1'b1);
    newLine(1023);
    scan(1016, 1023);
    scan(196, 210);
    newFrame();
    newLine(1020);
    scan(196, 210);

    // pixel_en alternating.
    for (int x = 196; x <= 212; x++) begin
      cyc(1, 0, 0, x, 0);
      cyc(0, 0, 0, x + 50, 0);
    end

    // frameStart and lineStart together: line test sees the incoming positions.
    setBall(0, 300, 400, 1'b1);
    setBall(1, 303, 405, 1'b1);
    cyc(0, 1, 1, 0, 406);
    scan(296, 315);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int by;
      by = int'($urandom_range(0, 1023));
      for (int i = 0; i < NB; i++) begin
        setBall(i, int'($urandom_range(0, 1023)),
                (by + int'($urandom_range(0, 12))) % 1024,
                1'($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 3) == 0) cyc(1, 1, 1, int'($urandom_range(0, 1023)), by + int'($urandom_range(0, 10)));
      else newFrame();
      for (int l = 0; l < 3; l++) begin
        int x0;
        newLine((by + int'($urandom_range(0, 20))) % 1024);
        x0 = int'(ballX[int'($urandom_range(0, NB - 1))*HW +: HW]) - int'($urandom_range(0, 6));
        for (int k = 0; k < 24; k++) begin
          cyc(1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, (x0 + k + 1024) % 1024, 0);
        end
      end
    end

    // Reset mid-line during a hit, then ballEn=0 ball is never reported.
    setBall(0, 100, 50, 1'b1);
    setBall(1, 104, 50, 1'b1);
    newFrame();
    newLine(52);
    scan(95, 105);
    chk("pre_rst_isBallPos", 32'(isBallPos), 32'd1);
    @(negedge clk);
    rst = 1'b1; pixelEn = 1'b0; frameStart = 1'b0; lineStart = 1'b0;
    modelReset();
    #1;
    chk("async_rst_isBallPos", 32'(isBallPos), 32'd0);
    chk("async_rst_overlap",   32'(overlap),   32'd0);
    chk("async_rst_collided",  32'(collided),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    scan(98, 110);
    setBall(0, 100, 50, 1'b0);
    newFrame();
    newLine(52);
    scan(98, 114);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
